// File: rtl/fpu_pkg.sv
// Shared types for the shift/normalise datapath: FSM states, the
// automatic operation select and the core register control word.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        NORM  = 2'd2,
        DONE  = 2'd3
    } shift_state_e;

    typedef enum logic {
        OP_ALIGN = 1'b0,
        OP_NORM  = 1'b1
    } shift_op_e;

    // Per-cycle action applied to the data register in the core.
    typedef enum logic [1:0] {
        CORE_HOLD  = 2'd0,
        CORE_LOAD  = 2'd1,
        CORE_LEFT  = 2'd2,
        CORE_RIGHT = 2'd3
    } core_ctrl_e;

endpackage

// File: rtl/norm_shift_core.sv
// Data register plus sticky flag. The controller picks one action per
// cycle; the inserted bit is supplied by the controller so the same
// shift path serves manual shifts and the automatic operations.
module norm_shift_core
    import fpu_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  core_ctrl_e       ctrl,
    input  logic             clr_sticky,
    input  logic [WIDTH-1:0] d,
    input  logic             shift_bit,
    output logic [WIDTH-1:0] q,
    output logic             sticky
);

    logic [WIDTH-1:0] q_reg;
    logic             sticky_reg;

    // Register update: load, one-bit left/right shift, or hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg      <= '0;
            sticky_reg <= 1'b0;
        end else begin
            unique case (ctrl)
                CORE_LOAD: begin
                    q_reg      <= d;
                    sticky_reg <= 1'b0;
                end
                CORE_LEFT: begin
                    // MSB falls off; sticky only tracks LSB-side losses.
                    q_reg <= {q_reg[WIDTH-2:0], shift_bit};
                    if (clr_sticky) sticky_reg <= 1'b0;
                end
                CORE_RIGHT: begin
                    q_reg      <= {shift_bit, q_reg[WIDTH-1:1]};
                    sticky_reg <= (sticky_reg & ~clr_sticky) | q_reg[0];
                end
                default: begin
                    if (clr_sticky) sticky_reg <= 1'b0;
                end
            endcase
        end
    end

    assign q      = q_reg;
    assign sticky = sticky_reg;

endmodule

// File: rtl/norm_shift_reg.sv
// Shift register with manual shifting plus two automatic operations:
// ALIGN (logical right shift by a clamped amount, collecting sticky) and
// NORM (left shift until the MSB is set, counting shifts).
module norm_shift_reg
    import fpu_pkg::*;
#(
    parameter  int WIDTH = 24,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             shift_en,
    input  logic             shift_dir,
    input  logic             serial_in,
    input  logic             start,
    input  logic             op,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic             sticky,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    shift_state_e     state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] n_reg, n_next;
    logic             zero_reg, zero_next;

    core_ctrl_e       core_ctrl;
    logic             clr_sticky;
    logic             shift_bit;
    logic [CNT_W-1:0] amount_clamped;
    shift_op_e        op_e;

    assign op_e           = shift_op_e'(op);
    assign amount_clamped = (amount > WIDTH_C) ? WIDTH_C : amount;

    norm_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .reset      (reset),
        .ctrl       (core_ctrl),
        .clr_sticky (clr_sticky),
        .d          (d),
        .shift_bit  (shift_bit),
        .q          (q),
        .sticky     (sticky)
    );

    // State, shift counter, ALIGN target and zero flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            n_reg     <= '0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            n_reg     <= n_next;
            zero_reg  <= zero_next;
        end
    end

    // Next-state and datapath control. The final shift of an automatic
    // operation moves straight to DONE, so done rises n+1 (or k+1) edges
    // after the start edge and busy lasts exactly n (or k) cycles.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        n_next     = n_reg;
        zero_next  = zero_reg;
        core_ctrl  = CORE_HOLD;
        clr_sticky = 1'b0;
        shift_bit  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (load) begin
                    core_ctrl  = CORE_LOAD;
                    count_next = '0;
                    zero_next  = 1'b0;
                end else if (start) begin
                    clr_sticky = 1'b1;
                    count_next = '0;
                    zero_next  = 1'b0;
                    if (op_e == OP_ALIGN) begin
                        n_next     = amount_clamped;
                        state_next = (amount_clamped == '0) ? DONE : ALIGN;
                    end else if (q == '0) begin
                        zero_next  = 1'b1;
                        state_next = DONE;
                    end else if (q[WIDTH-1]) begin
                        state_next = DONE;
                    end else begin
                        state_next = NORM;
                    end
                end else if (shift_en) begin
                    core_ctrl = shift_dir ? CORE_RIGHT : CORE_LEFT;
                    shift_bit = serial_in;
                end
            end
            ALIGN: begin
                core_ctrl  = CORE_RIGHT;
                count_next = count_reg + ONE_C;
                if (count_reg + ONE_C == n_reg) state_next = DONE;
            end
            NORM: begin
                core_ctrl  = CORE_LEFT;
                count_next = count_reg + ONE_C;
                // After this shift the current second-highest bit becomes MSB.
                if (q[WIDTH-2]) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign count = count_reg;
    assign zero  = zero_reg;
    assign busy  = (state_reg == ALIGN) || (state_reg == NORM);
    assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_norm_shift_reg.sv
// Randomised self-checking bench for norm_shift_reg at WIDTH = 8, with a
// behavioural model computing whole-operation results arithmetically.
module tb_norm_shift_reg;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [W-1:0]  d = '0;
    logic          shift_en = 1'b0;
    logic          shift_dir = 1'b0;
    logic          serial_in = 1'b0;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [CW-1:0] amount = '0;
    logic [W-1:0]  q;
    logic          sticky;
    logic [CW-1:0] count;
    logic          zero;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_q;
    bit           m_sticky;
    int           m_count;
    bit           m_zero;
    int           m_lat;
    int           m_busy;

    always #5 clk = ~clk;

    norm_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .load(load), .d(d),
        .shift_en(shift_en), .shift_dir(shift_dir), .serial_in(serial_in),
        .start(start), .op(op), .amount(amount),
        .q(q), .sticky(sticky), .count(count), .zero(zero),
        .busy(busy), .done(done)
    );

    function automatic int leading_zeros(input logic [W-1:0] v);
        int n = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) return n;
            n++;
        end
        return n;
    endfunction

    // Model of a whole automatic operation, computed in one step.
    task automatic model_auto(input bit o, input int amt);
        int n;
        if (!o) begin
            n = (amt > W) ? W : amt;
            m_sticky = 1'b0;
            for (int i = 0; i < n; i++) m_sticky = m_sticky | m_q[i];
            m_q     = (n >= W) ? '0 : (m_q >> n);
            m_count = n;
            m_zero  = 1'b0;
            m_lat   = n + 1;
            m_busy  = n;
        end else begin
            m_sticky = 1'b0;
            if (m_q == '0) begin
                m_zero  = 1'b1;
                m_count = 0;
            end else begin
                m_zero  = 1'b0;
                m_count = leading_zeros(m_q);
                m_q     = m_q << m_count;
            end
            m_lat  = m_count + 1;
            m_busy = m_count;
        end
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1;
        d    = v;
        @(negedge clk);
        load = 1'b0;
        m_q = v; m_sticky = 1'b0; m_count = 0; m_zero = 1'b0;
    endtask

    task automatic do_shift(input bit dir, input bit sin);
        shift_en  = 1'b1;
        shift_dir = dir;
        serial_in = sin;
        @(negedge clk);
        shift_en = 1'b0;
        if (dir) begin
            m_sticky = m_sticky | m_q[0];
            m_q = {sin, m_q[W-1:1]};
        end else begin
            m_q = {m_q[W-2:0], sin};
        end
    endtask

    // Launch an operation and observe it; optionally pulse load/start/shift
    // while busy. Leaves the bench aligned to a falling edge.
    task automatic run_auto(input bit o, input logic [CW-1:0] amt, input bit poke,
                            output int lat, output int busy_n, output int done_n);
        start = 1'b1; op = o; amount = amt;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_n = 0; done_n = 0;
        for (int i = 1; i <= 30; i++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat == 0) lat = i;
            end
            if (lat != 0 && i >= lat + 2) break;
            if (poke && i == 2) begin
                start = 1'b1; load = 1'b1; d = 8'h3C; shift_en = 1'b1;
                shift_dir = 1'b1; amount = 4'd1;
            end else begin
                start = 1'b0; load = 1'b0; shift_en = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; load = 1'b0; shift_en = 1'b0;
    endtask

    task automatic check_auto(input string tag, input int lat, input int busy_n, input int done_n);
        checks++;
        if (q !== m_q) begin errors++; $display("FAIL %s q got %h want %h", tag, q, m_q); end
        checks++;
        if (sticky !== m_sticky) begin errors++; $display("FAIL %s sticky got %b want %b", tag, sticky, m_sticky); end
        checks++;
        if (count !== CW'(m_count)) begin errors++; $display("FAIL %s count got %0d want %0d", tag, count, m_count); end
        checks++;
        if (zero !== m_zero) begin errors++; $display("FAIL %s zero got %b want %b", tag, zero, m_zero); end
        checks++;
        if (lat !== m_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", tag, lat, m_lat); end
        checks++;
        if (busy_n !== m_busy) begin errors++; $display("FAIL %s busy_cycles got %0d want %0d", tag, busy_n, m_busy); end
        checks++;
        if (done_n !== 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", tag, done_n); end
        $display("op %s q=%h sticky=%b count=%0d zero=%b lat=%0d", tag, q, sticky, count, zero, lat);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({q, sticky, count, zero, busy, done} !== '0) begin
            errors++; $display("FAIL reset_state got %h want 0", {q, sticky, count, zero, busy, done});
        end
        @(negedge clk);
        reset = 1'b0;
        m_q = '0; m_sticky = 0; m_count = 0; m_zero = 0;
        @(negedge clk);
        checks++;
        if ({q, busy, done} !== '0) begin
            errors++; $display("FAIL reset_release got %h want 0", {q, busy, done});
        end
        $display("reset released");
    endtask

    task automatic test_manual();
        do_load(8'h06);
        do_shift(1'b1, 1'b1);
        checks++;
        if (q !== 8'h83 || sticky !== 1'b0) begin
            errors++; $display("FAIL manual_r1 got %h/%b want 83/0", q, sticky);
        end
        do_shift(1'b1, 1'b1);
        checks++;
        if (q !== 8'hC1 || sticky !== 1'b1) begin
            errors++; $display("FAIL manual_r2 got %h/%b want c1/1", q, sticky);
        end
        do_load(W'($urandom));
        for (int i = 0; i < 20; i++) begin
            do_shift(1'($urandom), 1'($urandom));
            checks++;
            if (q !== m_q || sticky !== m_sticky) begin
                errors++; $display("FAIL manual_rand got %h/%b want %h/%b", q, sticky, m_q, m_sticky);
            end
            $display("shift %0d q=%h sticky=%b", i, q, sticky);
        end
    endtask

    task automatic test_align();
        int lat, bn, dn;
        do_load(8'hB5);
        model_auto(1'b0, 3);
        run_auto(1'b0, 4'd3, 1'b0, lat, bn, dn);
        check_auto("align_b5", lat, bn, dn);
        for (int i = 0; i < 10; i++) begin
            int a = int'($urandom_range(0, 15));
            do_load(W'($urandom));
            model_auto(1'b0, a);
            run_auto(1'b0, CW'(a), 1'b0, lat, bn, dn);
            check_auto("align_rand", lat, bn, dn);
        end
    endtask

    task automatic test_norm();
        int lat, bn, dn;
        do_load(8'h06);
        model_auto(1'b1, 0);
        run_auto(1'b1, 4'd0, 1'b0, lat, bn, dn);
        check_auto("norm_06", lat, bn, dn);
        for (int i = 0; i < 10; i++) begin
            // Narrow random values so shift counts vary across the range.
            do_load(W'($urandom) >> $urandom_range(0, W));
            model_auto(1'b1, 0);
            run_auto(1'b1, 4'd0, 1'b0, lat, bn, dn);
            check_auto("norm_rand", lat, bn, dn);
        end
    endtask

    task automatic test_corners();
        int lat, bn, dn;
        do_load(8'h00);
        model_auto(1'b1, 0);
        run_auto(1'b1, 4'd0, 1'b0, lat, bn, dn);
        check_auto("norm_zero", lat, bn, dn);
        do_load(8'h5A);
        model_auto(1'b0, 0);
        run_auto(1'b0, 4'd0, 1'b0, lat, bn, dn);
        check_auto("align_zero_amt", lat, bn, dn);
        do_load(8'h80);
        model_auto(1'b1, 0);
        run_auto(1'b1, 4'd0, 1'b0, lat, bn, dn);
        check_auto("norm_msb_set", lat, bn, dn);
    endtask

    task automatic test_clamp_ignore();
        int lat, bn, dn;
        do_load(8'hFF);
        model_auto(1'b0, 12);
        run_auto(1'b0, 4'd12, 1'b1, lat, bn, dn);
        check_auto("align_clamp_poke", lat, bn, dn);
    endtask

    task automatic test_priority();
        int lat, bn, dn;
        do_load(8'h11);
        // load and start together: load wins, no operation launched
        load = 1'b1; d = 8'h24; start = 1'b1; op = 1'b1;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        m_q = 8'h24;
        checks++;
        if (q !== m_q || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL prio_load got q=%h busy=%b done=%b want %h 0 0", q, busy, done, m_q);
        end
        // start and shift_en together: start wins, no shift happens
        shift_en = 1'b1; shift_dir = 1'b1; serial_in = 1'b1;
        model_auto(1'b0, 0);
        run_auto(1'b0, 4'd0, 1'b0, lat, bn, dn);
        shift_en = 1'b0;
        check_auto("prio_start", lat, bn, dn);
    endtask

    task automatic test_reset_mid();
        bit saw;
        do_load(8'h01);
        start = 1'b1; op = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({q, sticky, count, zero, busy, done} !== '0) begin
            errors++; $display("FAIL reset_mid got %h want 0", {q, sticky, count, zero, busy, done});
        end
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0 || q !== 8'h00) begin
            errors++; $display("FAIL reset_mid_after got activity=%b q=%h want 0 00", saw, q);
        end
        $display("reset mid-op q=%h busy=%b done=%b", q, busy, done);
    endtask

    initial begin
        test_reset();
        test_manual();
        test_align();
        test_norm();
        test_corners();
        test_clamp_ignore();
        test_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
